// File: rtl/router_port_scheduler_if.sv
// Handshake bundle between requesters, the port scheduler and the downstream port.
// master drives requests and out_ready; slave is the scheduler itself.
interface router_port_scheduler_if #(
    parameter int WIDTH = 39,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       in_valid;
    logic [NREQ*WIDTH-1:0] in_data;
    logic [NREQ-1:0]       in_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic                  out_ready;
    logic [1:0]            grant_id;
    logic [1:0]            occupancy;
    logic [15:0]           stall_cnt;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, grant_id, occupancy, stall_cnt
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, grant_id, occupancy, stall_cnt
    );
endinterface

// File: rtl/router_port_scheduler.sv
// Round-robin scheduler granting one of four requesters per cycle into a
// 2-entry output FIFO; counts cycles where requests are pending but none accepted.
module router_port_scheduler #(
    parameter int WIDTH = 39,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    router_port_scheduler_if.slave bus
);
    localparam int PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0] ptr_reg;
    logic [1:0]       grant_reg;
    logic [1:0]       occ_reg;
    logic             rd_idx_reg;
    logic             wr_idx_reg;
    logic [15:0]      stall_reg;
    logic [WIDTH-1:0] fifo_mem_reg [2];

    logic [PTR_W-1:0] cand_idx [NREQ];
    logic [NREQ-1:0]  rot_valid;
    logic             grant_hit;
    logic [PTR_W-1:0] grant_idx;
    logic [NREQ-1:0]  ready_vec;
    logic             push;
    logic             pop;
    logic             out_valid_int;

    // Candidate gi is the requester gi places after the pointer.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
            assign cand_idx[gi]  = ptr_reg + PTR_W'(gi);
            assign rot_valid[gi] = bus.in_valid[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                grant_hit = 1'b1;
                grant_idx = cand_idx[k];
            end
        end
    end

    // A full queue refuses input even when it is popped this cycle.
    always_comb begin
        ready_vec = '0;
        if (rst_n && grant_hit && (occ_reg != 2'd2)) begin
            ready_vec[grant_idx] = 1'b1;
        end
    end

    assign push          = |ready_vec;
    assign out_valid_int = rst_n && (occ_reg != 2'd0);
    assign pop           = out_valid_int && bus.out_ready;

    assign bus.in_ready  = ready_vec;
    assign bus.out_valid = out_valid_int;
    assign bus.out_data  = fifo_mem_reg[rd_idx_reg];
    assign bus.grant_id  = grant_reg;
    assign bus.occupancy = occ_reg;
    assign bus.stall_cnt = stall_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_reg    <= '0;
            grant_reg  <= '0;
            occ_reg    <= '0;
            rd_idx_reg <= 1'b0;
            wr_idx_reg <= 1'b0;
            stall_reg  <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_mem_reg[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem_reg[wr_idx_reg] <= bus.in_data[grant_idx*WIDTH +: WIDTH];
                wr_idx_reg               <= ~wr_idx_reg;
                ptr_reg                  <= grant_idx + PTR_W'(1);
                grant_reg                <= 2'(grant_idx);
            end
            if (pop) begin
                rd_idx_reg <= ~rd_idx_reg;
            end
            case ({push, pop})
                2'b10:   occ_reg <= occ_reg + 2'd1;
                2'b01:   occ_reg <= occ_reg - 2'd1;
                default: occ_reg <= occ_reg;
            endcase
            if ((|bus.in_valid) && !push && (stall_reg != 16'hFFFF)) begin
                stall_reg <= stall_reg + 16'd1;
            end
        end
    end
endmodule
